// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM. One memory port is shared between instruction
// fetch and load/store. Accesses use a mem_req/mem_ready handshake, so slow
// memory stalls the FSM.
// MEM_TIMEOUT > 0 bounds each memory wait; after that many cycles without
// mem_ready, mem_err pulses for one cycle and the FSM returns to FETCH.
// Optional feature macro: MC_PERF_CNT_EN adds the cycle_cnt and instr_cnt
// performance counters.
module mips_mc_controller #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic        illegal,
    output logic        mem_err,
    output logic [3:0]  state_dbg
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state, state_nxt;
    logic   mem_wait;    // in a memory state and memory not ready
    logic   timeout;     // this wait cycle exhausts the budget
    logic   completing;  // instruction retires on this clock edge

    // A memory state waiting on the handshake.
    assign mem_wait = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;

    // The counter holds the number of wait cycles already spent in the current
    // memory state. The wait that would bring it to MEM_TIMEOUT is the
    // timeout cycle.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [CW-1:0] wait_cnt;

            assign timeout = mem_wait && (wait_cnt == CW'(MEM_TIMEOUT - 1));

            // Count consecutive waits. Clear on any exit, so every entry starts at 0.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                   wait_cnt <= '0;
                else if (mem_wait && !timeout) wait_cnt <= wait_cnt + CW'(1);
                else                          wait_cnt <= '0;
            end
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    assign state_dbg = state;

    // Next-state and Moore outputs. All outputs are held at 0 while reset is low.
    always_comb begin
        state_nxt   = FETCH;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        illegal     = 1'b0;
        mem_err     = 1'b0;
        completing  = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = 3'b010;
                    ir_write    = mem_ready;
                    pc_en       = mem_ready;
                    if (mem_ready)    state_nxt = DECODE;
                    else if (timeout) mem_err   = 1'b1;
                    else              state_nxt = FETCH;
                end
                DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = 3'b010;
                    case (op)
                        OP_LW, OP_SW: state_nxt = MEMADR;
                        OP_BEQ:       state_nxt = BRANCH;
                        OP_ADDI:      state_nxt = ADDIEX;
                        OP_J:         state_nxt = JUMP;
                        OP_RTYPE: begin
                            case (funct)
                                FN_JR:                           state_nxt = JR;
                                6'b100000, 6'b100010, 6'b100100,
                                6'b100101, 6'b101010:            state_nxt = EXEC;
                                default:                         illegal   = 1'b1;
                            endcase
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                MEMADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = 3'b010;
                    state_nxt   = (op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready)    state_nxt = MEMWB;
                    else if (timeout) mem_err   = 1'b1;
                    else              state_nxt = MEMRD;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    completing = 1'b1;
                end
                MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready)    completing = 1'b1;
                    else if (timeout) mem_err    = 1'b1;
                    else              state_nxt  = MEMWR;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    state_nxt = ALUWB;
                    case (funct)
                        6'b100010: alu_control = 3'b110;
                        6'b100100: alu_control = 3'b000;
                        6'b100101: alu_control = 3'b001;
                        6'b101010: alu_control = 3'b111;
                        default:   alu_control = 3'b010;
                    endcase
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    completing = 1'b1;
                end
                BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = 3'b110;
                    pc_src      = 2'b01;
                    pc_en       = zero;
                    completing  = 1'b1;
                end
                ADDIEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = 3'b010;
                    state_nxt   = ADDIWB;
                end
                ADDIWB: begin
                    reg_write  = 1'b1;
                    completing = 1'b1;
                end
                JUMP: begin
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                    completing = 1'b1;
                end
                JR: begin
                    pc_src     = 2'b11;
                    pc_en      = 1'b1;
                    completing = 1'b1;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    // Free-running cycle count and retired-instruction count. Both wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            instr_cnt <= instr_cnt + 32'(completing);
        end
    end
`else
    // Keeps the retire flag visibly consumed when the counters are not built.
    logic unused_completing;
    assign unused_completing = completing;
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller (built with MEM_TIMEOUT=4).
// Every cycle, each test pushes the expected output vector together with the
// input stimulus for that cycle. The drain task then applies each entry and
// compares the DUT outputs.
module tb_mips_mc_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal, mem_err;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mips_mc_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .illegal(illegal), .mem_err(mem_err), .state_dbg(state_dbg)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_write, iord, ir_write, pc_en;
        logic [1:0] pc_src;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       illegal, mem_err;
    } obs_t;

    typedef struct {
        logic [5:0] op, fn;
        logic       rdy, z, fin;
        obs_t       exp;
        string      nm;
    } step_t;

    obs_t obs;
    assign obs = {state_dbg, mem_req, mem_write, iord, ir_write, pc_en, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  alu_control, illegal, mem_err};

    step_t       q[$];
    int          n_cmp = 0, n_err = 0;
    int unsigned exp_instr = 0;
    logic [5:0]  cur_op, cur_fn;
`ifdef MC_PERF_CNT_EN
    logic [31:0] prev_cyc;
    bit          have_prev = 0;
`endif

    // Expected outputs for one state, taken from the control table.
    function automatic obs_t spec_out(input logic [3:0] st, input logic rdy, z,
                                      input logic [5:0] fn, input logic ill, err);
        obs_t o = '0;
        o.st = st;
        o.illegal = ill;
        o.mem_err = err;
        case (st)
            4'd0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_control = 3'b010;
                         o.ir_write = rdy; o.pc_en = rdy; end
            4'd1:  begin o.alu_src_b = 2'b11; o.alu_control = 3'b010; end
            4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            4'd3:  begin o.mem_req = 1; o.iord = 1; end
            4'd4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd5:  begin o.mem_req = 1; o.mem_write = 1; o.iord = 1; end
            4'd6:  begin
                       o.alu_src_a = 1;
                       case (fn)
                           6'b100000: o.alu_control = 3'b010;
                           6'b100010: o.alu_control = 3'b110;
                           6'b100100: o.alu_control = 3'b000;
                           6'b100101: o.alu_control = 3'b001;
                           default:   o.alu_control = 3'b111;
                       endcase
                   end
            4'd7:  begin o.reg_write = 1; o.reg_dst = 1; end
            4'd8:  begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_en = z; end
            4'd9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            4'd10: o.reg_write = 1;
            4'd11: begin o.pc_src = 2'b10; o.pc_en = 1; end
            4'd12: begin o.pc_src = 2'b11; o.pc_en = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, z, ill, err, fin, input string nm);
        step_t s;
        s.op = cur_op; s.fn = cur_fn; s.rdy = rdy; s.z = z; s.fin = fin; s.nm = nm;
        s.exp = spec_out(st, rdy, z, cur_fn, ill, err);
        q.push_back(s);
    endtask

    task automatic set_instr(input logic [31:0] ir);
        cur_op = ir[31:26];
        cur_fn = ir[5:0];
    endtask

    // Apply queued stimulus one cycle at a time and compare outputs mid-cycle.
    task automatic drain();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            op = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z;
            #1;
            n_cmp++;
            if (obs !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %h need %h", s.nm, obs, s.exp);
            end
`ifdef MC_PERF_CNT_EN
            n_cmp++;
            if (instr_cnt !== exp_instr) begin
                n_err++;
                $display("FAIL %s instr_cnt: got %0d need %0d", s.nm, instr_cnt, exp_instr);
            end
            if (have_prev) begin
                n_cmp++;
                if (cycle_cnt !== prev_cyc + 32'd2) begin
                    n_err++;
                    $display("FAIL %s cycle_cnt: got %0d need %0d", s.nm, cycle_cnt, prev_cyc + 32'd2);
                end
            end
            prev_cyc  = cycle_cnt - 32'd1;
            have_prev = 1;
`endif
            if (s.fin) exp_instr++;
        end
    endtask

    // Check the all-zero reset outputs, then release reset and check the first FETCH.
    task automatic check_reset_then_release(input string nm);
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL %s in reset: got %h need %h", nm, obs, obs_t'(0));
        end
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 0 || instr_cnt !== 0) begin
            n_err++;
            $display("FAIL %s perf in reset: got %0d/%0d need 0/0", nm, cycle_cnt, instr_cnt);
        end
        have_prev = 0;
`endif
        exp_instr = 0;
        @(negedge clk);
        mem_ready = 0;
        reset = 1;
        #1;
        n_cmp++;
        if (obs !== spec_out(4'd0, 1'b0, 1'b0, funct, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL %s release: got %h need %h", nm, obs,
                     spec_out(4'd0, 1'b0, 1'b0, funct, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        #3;
        check_reset_then_release("reset");
    endtask

    task automatic test_lw();
        set_instr(32'h8C080004);
        push(4'd0, 1, 0, 0, 0, 0, "lw/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "lw/DECODE");
        push(4'd2, 1, 0, 0, 0, 0, "lw/MEMADR");
        push(4'd3, 1, 0, 0, 0, 0, "lw/MEMRD");
        push(4'd4, 1, 0, 0, 0, 1, "lw/MEMWB");
        drain();
    endtask

    task automatic test_add_stall();
        set_instr(32'h01095020);
        for (int i = 0; i < 3; i++) push(4'd0, 0, 0, 0, 0, 0, "add/FETCH-wait");
        push(4'd0, 1, 0, 0, 0, 0, "add/FETCH-go");
        push(4'd1, 1, 0, 0, 0, 0, "add/DECODE");
        push(4'd6, 1, 0, 0, 0, 0, "add/EXEC");
        push(4'd7, 1, 0, 0, 0, 1, "add/ALUWB");
        drain();
    endtask

    task automatic test_beq();
        set_instr(32'h11090003);
        for (int t = 1; t >= 0; t--) begin
            push(4'd0, 1, t[0], 0, 0, 0, "beq/FETCH");
            push(4'd1, 1, t[0], 0, 0, 0, "beq/DECODE");
            push(4'd8, 1, t[0], 0, 0, 1, t ? "beq/BRANCH-taken" : "beq/BRANCH-not");
        end
        drain();
    endtask

    task automatic test_jr_illegal();
        set_instr(32'h03E00008);
        push(4'd0, 1, 0, 0, 0, 0, "jr/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "jr/DECODE");
        push(4'd12, 1, 0, 0, 0, 1, "jr/JR");
        set_instr(32'hFC000000);
        push(4'd0, 1, 0, 0, 0, 0, "ill-op/FETCH");
        push(4'd1, 1, 0, 1, 0, 0, "ill-op/DECODE");
        set_instr(32'h01095007);
        push(4'd0, 1, 0, 0, 0, 0, "ill-fn/FETCH");
        push(4'd1, 1, 0, 1, 0, 0, "ill-fn/DECODE");
        set_instr(32'h08000010);
        push(4'd0, 1, 0, 0, 0, 0, "j/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "j/DECODE");
        push(4'd11, 1, 0, 0, 0, 1, "j/JUMP");
        drain();
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        set_instr(32'hAC080004);
        push(4'd0, 1, 0, 0, 0, 0, "sw/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "sw/DECODE");
        push(4'd2, 1, 0, 0, 0, 0, "sw/MEMADR");
        push(4'd5, 1, 0, 0, 0, 1, "sw/MEMWR");
        set_instr(32'h21080001);
        push(4'd0, 1, 0, 0, 0, 0, "addi/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "addi/DECODE");
        push(4'd9, 1, 0, 0, 0, 0, "addi/ADDIEX");
        push(4'd10, 1, 0, 0, 0, 1, "addi/ADDIWB");
        for (int i = 0; i < 4; i++) begin
            set_instr({26'h0084800, fns[i]});
            push(4'd0, 1, 0, 0, 0, 0, "rtype/FETCH");
            push(4'd1, 1, 0, 0, 0, 0, "rtype/DECODE");
            push(4'd6, 1, 0, 0, 0, 0, "rtype/EXEC");
            push(4'd7, 1, 0, 0, 0, 1, "rtype/ALUWB");
        end
        set_instr(32'h8C080004);
        push(4'd0, 1, 0, 0, 0, 0, "lw2/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "lw2/DECODE");
        push(4'd2, 1, 0, 0, 0, 0, "lw2/MEMADR");
        for (int i = 0; i < TO - 1; i++) push(4'd3, 0, 0, 0, 0, 0, "lw2/MEMRD-wait");
        push(4'd3, 1, 0, 0, 0, 0, "lw2/MEMRD-go");
        push(4'd4, 1, 0, 0, 0, 1, "lw2/MEMWB");
        drain();
    endtask

    task automatic test_timeout();
        set_instr(32'hAC080004);
        push(4'd0, 1, 0, 0, 0, 0, "to-sw/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "to-sw/DECODE");
        push(4'd2, 1, 0, 0, 0, 0, "to-sw/MEMADR");
        for (int i = 0; i < TO - 1; i++) push(4'd5, 0, 0, 0, 0, 0, "to-sw/MEMWR-wait");
        push(4'd5, 0, 0, 0, 1, 0, "to-sw/MEMWR-timeout");
        set_instr(32'h08000010);
        for (int i = 0; i < TO - 1; i++) push(4'd0, 0, 0, 0, 0, 0, "to-fetch/wait");
        push(4'd0, 0, 0, 0, 1, 0, "to-fetch/timeout");
        push(4'd0, 1, 0, 0, 0, 0, "to-j/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "to-j/DECODE");
        push(4'd11, 1, 0, 0, 0, 1, "to-j/JUMP");
        drain();
    endtask

    task automatic test_reset_mid();
        set_instr(32'h8C080004);
        push(4'd0, 1, 0, 0, 0, 0, "rst-lw/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "rst-lw/DECODE");
        push(4'd2, 1, 0, 0, 0, 0, "rst-lw/MEMADR");
        push(4'd3, 0, 0, 0, 0, 0, "rst-lw/MEMRD-wait");
        push(4'd3, 0, 0, 0, 0, 0, "rst-lw/MEMRD-wait");
        drain();
        #2;
        reset = 0;
        #1;
        check_reset_then_release("reset-mid-memrd");
        set_instr(32'h08000010);
        push(4'd0, 1, 0, 0, 0, 0, "post-rst/FETCH");
        push(4'd1, 1, 0, 0, 0, 0, "post-rst/DECODE");
        push(4'd11, 1, 0, 0, 0, 1, "post-rst/JUMP");
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_add_stall();
        test_beq();
        test_jr_illegal();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
